// File: rtl/cp0_intc_pkg.sv
// Shared CP0 definitions for the interrupt controller: register addresses,
// level width and the layout of one EPC stack entry.
package cp0_intc_pkg;

    localparam logic [4:0] CP0_LEVEL = 5'h0c;
    localparam logic [4:0] CP0_PEND  = 5'h0d;
    localparam logic [4:0] CP0_EPC   = 5'h0e;
    localparam logic [4:0] CP0_IE    = 5'h16;
    localparam logic [4:0] CP0_MASK  = 5'h17;

    // Level 0 means "not in an ISR"; channel i runs at level i+1, so 8 channels need 4 bits.
    localparam int LEVEL_W = 4;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [2:0]         cand_t;

    typedef struct packed {
        logic [31:0] pc;
        level_t      level;
    } epc_entry_t;

endpackage

// File: rtl/cp0_intc_if.sv
// CP0 register access port: mtc0 writes and the combinational mfc0 read of cp0_addr.
interface cp0_intc_if;

    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_data;
    logic [31:0] mfc0_data;

    modport master (
        output mtc0_we,
        output cp0_addr,
        output mtc0_data,
        input  mfc0_data
    );

    modport slave (
        input  mtc0_we,
        input  cp0_addr,
        input  mtc0_data,
        output mfc0_data
    );

endinterface

// File: rtl/cp0_epc_stack.sv
// LIFO of {return pc, interrupted level} pairs; pop wins over push and over a top-entry rewrite.
module cp0_epc_stack
    import cp0_intc_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  epc_entry_t  push_data,
    input  logic        wr_top,
    input  logic [31:0] wr_pc,
    output epc_entry_t  top,
    output logic        empty
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    epc_entry_t     mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] top_idx;

    assign sp_m1   = sp - SPW'(1);
    assign wr_idx  = sp[IDXW-1:0];
    assign top_idx = sp_m1[IDXW-1:0];
    assign empty   = (sp == '0);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end else if (push && (sp != SPW'(DEPTH))) begin
            mem[wr_idx] <= push_data;
            sp          <= sp + SPW'(1);
        end else if (wr_top && !empty) begin
            mem[top_idx].pc <= wr_pc;
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// Prioritised, nestable interrupt controller living in CP0: edge-detects irq lines,
// redirects the pipeline to a per-channel vector and keeps a stack of return PCs/levels.
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter int          N_IRQ      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h400,
    parameter logic [31:0] VEC_STRIDE = 32'h200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_raw,
    input  logic             pipe_ready,
    input  logic [31:0]      pc_next,
    input  logic             eret,
    cp0_intc_if.slave        cp0,
    output logic             irq_take,
    output logic [31:0]      irq_vector,
    output logic [31:0]      epc,
    output logic             eret_err
);

    logic [N_IRQ-1:0] prev;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] take_clr;
    logic             ie;
    level_t           level;
    level_t           cand_level;
    cand_t            cand;
    logic             cand_valid;
    logic             wr_ie;
    logic             wr_mask;
    logic             wr_pend;
    logic             wr_epc;
    epc_entry_t       push_data;
    epc_entry_t       top;
    logic             stack_empty;

    assign wr_ie   = cp0.mtc0_we && (cp0.cp0_addr == CP0_IE);
    assign wr_mask = cp0.mtc0_we && (cp0.cp0_addr == CP0_MASK);
    assign wr_pend = cp0.mtc0_we && (cp0.cp0_addr == CP0_PEND);
    assign wr_epc  = cp0.mtc0_we && (cp0.cp0_addr == CP0_EPC);

    assign rise   = irq_raw & ~prev;
    assign active = pending & mask;
    assign w1c    = wr_pend ? cp0.mtc0_data[N_IRQ-1:0] : '0;

    // Ascending scan so the highest-numbered active channel is the one left in cand.
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (active[i]) begin
                cand_valid = 1'b1;
                cand       = cand_t'(i);
            end
        end
    end

    assign cand_level = {1'b0, cand} + level_t'(1);
    assign irq_take   = cand_valid & ie & (cand_level > level) & pipe_ready & ~eret;
    assign irq_vector = irq_take
                      ? VEC_BASE + ((32'(N_IRQ - 1) - 32'(cand)) * VEC_STRIDE)
                      : '0;
    assign take_clr   = irq_take ? (N_IRQ'(1) << cand) : '0;

    assign push_data.pc    = pc_next;
    assign push_data.level = level;
    assign epc             = top.pc;

    cp0_epc_stack #(
        .DEPTH (N_IRQ)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (irq_take),
        .pop       (eret),
        .push_data (push_data),
        .wr_top    (wr_epc),
        .wr_pc     (cp0.mtc0_data),
        .top       (top),
        .empty     (stack_empty)
    );

    // A rising edge re-arms a channel even if software clears it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            pending  <= '0;
            mask     <= '0;
            ie       <= 1'b0;
            level    <= '0;
            eret_err <= 1'b0;
        end else begin
            prev    <= irq_raw;
            pending <= (pending & ~(w1c | take_clr)) | rise;
            if (wr_ie) begin
                ie <= cp0.mtc0_data[0];
            end
            if (wr_mask) begin
                mask <= cp0.mtc0_data[N_IRQ-1:0];
            end
            if (eret) begin
                if (stack_empty) begin
                    eret_err <= 1'b1;
                end else begin
                    level <= top.level;
                end
            end else if (irq_take) begin
                level <= cand_level;
            end
        end
    end

    always_comb begin
        cp0.mfc0_data = '0;
        case (cp0.cp0_addr)
            CP0_IE:    cp0.mfc0_data = {31'b0, ie};
            CP0_MASK:  cp0.mfc0_data = 32'(mask);
            CP0_PEND:  cp0.mfc0_data = 32'(pending);
            CP0_LEVEL: cp0.mfc0_data = 32'(level);
            CP0_EPC:   cp0.mfc0_data = top.pc;
            default:   cp0.mfc0_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: a vector table for take/nest/return flows, then
// hand sequences for gating, W1C races, eret collisions and asynchronous reset.
module tb_cp0_intc;
    import cp0_intc_pkg::*;

    typedef struct {
        logic [2:0]  irq;
        logic        rdy;
        logic [31:0] pc;
        logic        er;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        e_take;
        logic [31:0] e_vec;
        logic [31:0] e_epc;
        logic [31:0] e_mfc0;
        logic        e_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  irq_raw;
    logic        pipe_ready;
    logic [31:0] pc_next;
    logic        eret;
    logic        irq_take;
    logic [31:0] irq_vector;
    logic [31:0] epc;
    logic        eret_err;
    int          total;
    int          bad;
    vec_t        vecs [32];

    cp0_intc_if bus ();

    cp0_intc #(
        .N_IRQ      (3),
        .VEC_BASE   (32'h400),
        .VEC_STRIDE (32'h200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_raw    (irq_raw),
        .pipe_ready (pipe_ready),
        .pc_next    (pc_next),
        .eret       (eret),
        .cp0        (bus),
        .irq_take   (irq_take),
        .irq_vector (irq_vector),
        .epc        (epc),
        .eret_err   (eret_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        irq_raw       = v.irq;
        pipe_ready    = v.rdy;
        pc_next       = v.pc;
        eret          = v.er;
        bus.mtc0_we   = v.we;
        bus.cp0_addr  = v.addr;
        bus.mtc0_data = v.wd;
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge: drive, let comb settle, compare, then cross one rising edge.
    task automatic runVec(input string nm, input vec_t v);
        applyStimulus(v);
        #1;
        checkOutput({nm, " take"}, 32'(irq_take), 32'(v.e_take));
        checkOutput({nm, " vector"}, irq_vector, v.e_vec);
        checkOutput({nm, " epc"}, epc, v.e_epc);
        checkOutput({nm, " mfc0"}, bus.mfc0_data, v.e_mfc0);
        checkOutput({nm, " eret_err"}, 32'(eret_err), 32'(v.e_err));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runStep(input string nm, input logic [2:0] irq, input logic rdy,
                           input logic [31:0] pc, input logic er, input logic we,
                           input logic [4:0] addr, input logic [31:0] wd, input logic t,
                           input logic [31:0] vec, input logic [31:0] ep,
                           input logic [31:0] m, input logic err);
        vec_t v;
        v = '{irq, rdy, pc, er, we, addr, wd, t, vec, ep, m, err};
        runVec(nm, v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus('{3'b000, 1'b0, 32'h0, 1'b0, 1'b0, CP0_LEVEL, 32'h0,
                        1'b0, 32'h0, 32'h0, 32'h0, 1'b0});

        //        irq     rdy   pc          eret  we    addr       wdata        take  vector      epc         mfc0        err
        vecs[0]  = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b1, CP0_IE,    32'h1,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[1]  = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b1, CP0_MASK,  32'h7,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[2]  = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b0, CP0_IE,    32'h0,   1'b0, 32'h000, 32'h000, 32'h001, 1'b0};
        vecs[3]  = '{3'b010, 1'b1, 32'h100, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[4]  = '{3'b000, 1'b1, 32'h100, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h600, 32'h000, 32'h002, 1'b0};
        vecs[5]  = '{3'b000, 1'b1, 32'h104, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h100, 32'h002, 1'b0};
        vecs[6]  = '{3'b000, 1'b1, 32'h104, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b0, 32'h000, 32'h100, 32'h000, 1'b0};
        vecs[7]  = '{3'b000, 1'b1, 32'h108, 1'b1, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h100, 32'h002, 1'b0};
        vecs[8]  = '{3'b000, 1'b1, 32'h108, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[9]  = '{3'b001, 1'b1, 32'h200, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[10] = '{3'b000, 1'b1, 32'h200, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h800, 32'h000, 32'h001, 1'b0};
        vecs[11] = '{3'b100, 1'b1, 32'h820, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h200, 32'h001, 1'b0};
        vecs[12] = '{3'b000, 1'b1, 32'h820, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h400, 32'h200, 32'h004, 1'b0};
        vecs[13] = '{3'b000, 1'b1, 32'h824, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h820, 32'h003, 1'b0};
        vecs[14] = '{3'b000, 1'b1, 32'h824, 1'b1, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h820, 32'h003, 1'b0};
        vecs[15] = '{3'b000, 1'b1, 32'h204, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h200, 32'h001, 1'b0};
        vecs[16] = '{3'b000, 1'b1, 32'h204, 1'b1, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h200, 32'h001, 1'b0};
        vecs[17] = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[18] = '{3'b100, 1'b1, 32'h300, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[19] = '{3'b000, 1'b1, 32'h300, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h400, 32'h000, 32'h004, 1'b0};
        vecs[20] = '{3'b010, 1'b1, 32'h340, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b0, 32'h000, 32'h300, 32'h000, 1'b0};
        vecs[21] = '{3'b000, 1'b1, 32'h340, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b0, 32'h000, 32'h300, 32'h002, 1'b0};
        vecs[22] = '{3'b000, 1'b1, 32'h340, 1'b1, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h300, 32'h003, 1'b0};
        vecs[23] = '{3'b000, 1'b0, 32'h380, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[24] = '{3'b000, 1'b1, 32'h380, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h600, 32'h000, 32'h002, 1'b0};
        vecs[25] = '{3'b000, 1'b1, 32'h384, 1'b0, 1'b1, CP0_EPC,   32'h388, 1'b0, 32'h000, 32'h380, 32'h380, 1'b0};
        vecs[26] = '{3'b000, 1'b1, 32'h384, 1'b1, 1'b0, CP0_EPC,   32'h0,   1'b0, 32'h000, 32'h388, 32'h388, 1'b0};
        vecs[27] = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[28] = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b1, CP0_EPC,   32'h999, 1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[29] = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b0, CP0_EPC,   32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[30] = '{3'b000, 1'b1, 32'h000, 1'b1, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b0};
        vecs[31] = '{3'b000, 1'b1, 32'h000, 1'b0, 1'b0, 5'h01,     32'h0,   1'b0, 32'h000, 32'h000, 32'h000, 1'b1};

        #2;
        checkOutput("reset take", 32'(irq_take), 32'h0);
        checkOutput("reset vector", irq_vector, 32'h0);
        checkOutput("reset epc", epc, 32'h0);
        checkOutput("reset eret_err", 32'(eret_err), 32'h0);
        checkOutput("reset level", bus.mfc0_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Each gate is shown blocking on its own while the other two are open.
        runStep("gate0", 3'b000, 1'b1, 32'h0,   1'b0, 1'b1, CP0_MASK,  32'h0, 1'b0, 32'h0,   32'h0,   32'h7,   1'b1);
        runStep("gate1", 3'b001, 1'b1, 32'h0,   1'b0, 1'b0, CP0_PEND,  32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("gate2", 3'b000, 1'b1, 32'h0,   1'b0, 1'b0, CP0_PEND,  32'h0, 1'b0, 32'h0,   32'h0,   32'h1,   1'b1);
        runStep("gate3", 3'b000, 1'b1, 32'h0,   1'b0, 1'b1, CP0_IE,    32'h0, 1'b0, 32'h0,   32'h0,   32'h1,   1'b1);
        runStep("gate4", 3'b000, 1'b1, 32'h0,   1'b0, 1'b1, CP0_MASK,  32'h1, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("gate5", 3'b000, 1'b1, 32'h0,   1'b0, 1'b0, CP0_PEND,  32'h0, 1'b0, 32'h0,   32'h0,   32'h1,   1'b1);
        runStep("gate6", 3'b000, 1'b0, 32'h0,   1'b0, 1'b1, CP0_IE,    32'h1, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("gate7", 3'b000, 1'b0, 32'h0,   1'b0, 1'b0, CP0_PEND,  32'h0, 1'b0, 32'h0,   32'h0,   32'h1,   1'b1);
        runStep("gate8", 3'b000, 1'b1, 32'h500, 1'b0, 1'b0, CP0_PEND,  32'h0, 1'b1, 32'h800, 32'h0,   32'h1,   1'b1);
        runStep("gate9", 3'b000, 1'b1, 32'h504, 1'b1, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'h500, 32'h1,   1'b1);

        // Channel 1 is masked here, so pending can be poked without triggering takes.
        runStep("w1c0", 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        runStep("w1c1", 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1);
        runStep("w1c2", 3'b000, 1'b1, 32'h0, 1'b0, 1'b1, CP0_PEND, 32'h2, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1);
        runStep("w1c3", 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        runStep("w1c4", 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        runStep("w1c5", 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1);
        runStep("w1c6", 3'b010, 1'b1, 32'h0, 1'b0, 1'b1, CP0_PEND, 32'h2, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1);
        runStep("w1c7", 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1);
        runStep("w1c8", 3'b010, 1'b1, 32'h0, 1'b0, 1'b1, CP0_PEND, 32'h2, 1'b0, 32'h0, 32'h0, 32'h2, 1'b1);
        runStep("w1c9", 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, CP0_PEND, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        runStep("col0", 3'b000, 1'b1, 32'h0,   1'b0, 1'b1, CP0_MASK,  32'h7, 1'b0, 32'h0,   32'h0,   32'h1,   1'b1);
        runStep("col1", 3'b001, 1'b1, 32'h600, 1'b0, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("col2", 3'b000, 1'b1, 32'h600, 1'b0, 1'b0, CP0_LEVEL, 32'h0, 1'b1, 32'h800, 32'h0,   32'h0,   1'b1);
        runStep("col3", 3'b100, 1'b1, 32'h604, 1'b0, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'h600, 32'h1,   1'b1);
        runStep("col4", 3'b000, 1'b1, 32'h604, 1'b1, 1'b0, CP0_PEND,  32'h0, 1'b0, 32'h0,   32'h600, 32'h4,   1'b1);
        runStep("col5", 3'b000, 1'b1, 32'h700, 1'b0, 1'b0, CP0_LEVEL, 32'h0, 1'b1, 32'h400, 32'h0,   32'h0,   1'b1);
        runStep("col6", 3'b000, 1'b1, 32'h704, 1'b1, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'h700, 32'h3,   1'b1);

        // Build a two-deep nest, checking that an eret beats a same-cycle EPC write.
        runStep("nest0", 3'b001, 1'b1, 32'hA00, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("nest1", 3'b000, 1'b1, 32'hA00, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h800, 32'h0,   32'h1,   1'b1);
        runStep("nest2", 3'b010, 1'b1, 32'hB00, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h0,   32'hA00, 32'h1,   1'b1);
        runStep("nest3", 3'b000, 1'b1, 32'hB00, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h600, 32'hA00, 32'h2,   1'b1);
        runStep("nest4", 3'b000, 1'b1, 32'hB04, 1'b1, 1'b1, CP0_EPC,   32'hBAD, 1'b0, 32'h0,   32'hB00, 32'hB00, 1'b1);
        runStep("nest5", 3'b000, 1'b1, 32'hA04, 1'b0, 1'b0, CP0_EPC,   32'h0,   1'b0, 32'h0,   32'hA00, 32'hA00, 1'b1);
        runStep("nest6", 3'b010, 1'b1, 32'hB40, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h0,   32'hA00, 32'h1,   1'b1);
        runStep("nest7", 3'b000, 1'b1, 32'hB40, 1'b0, 1'b0, CP0_PEND,  32'h0,   1'b1, 32'h600, 32'hA00, 32'h2,   1'b1);
        runStep("nest8", 3'b100, 1'b1, 32'hC00, 1'b0, 1'b0, CP0_LEVEL, 32'h0,   1'b0, 32'h0,   32'hB40, 32'h2,   1'b1);

        // Reset pulse entirely between clock edges while a take is being asserted.
        applyStimulus('{3'b000, 1'b1, 32'hC40, 1'b0, 1'b0, CP0_LEVEL, 32'h0,
                        1'b0, 32'h0, 32'h0, 32'h0, 1'b0});
        #1;
        checkOutput("prerst take", 32'(irq_take), 32'h1);
        checkOutput("prerst vector", irq_vector, 32'h400);
        checkOutput("prerst epc", epc, 32'hB40);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst take", 32'(irq_take), 32'h0);
        checkOutput("rst vector", irq_vector, 32'h0);
        checkOutput("rst epc", epc, 32'h0);
        checkOutput("rst eret_err", 32'(eret_err), 32'h0);
        checkOutput("rst level", bus.mfc0_data, 32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        runStep("post0", 3'b000, 1'b1, 32'h0,   1'b0, 1'b0, CP0_IE,    32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b0);
        runStep("post1", 3'b000, 1'b1, 32'h0,   1'b0, 1'b0, CP0_MASK,  32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b0);
        runStep("post2", 3'b000, 1'b1, 32'h0,   1'b0, 1'b0, CP0_PEND,  32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b0);
        runStep("post3", 3'b000, 1'b1, 32'h0,   1'b1, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b0);
        runStep("post4", 3'b000, 1'b1, 32'h0,   1'b0, 1'b1, CP0_IE,    32'h1, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("post5", 3'b000, 1'b1, 32'h0,   1'b0, 1'b1, CP0_MASK,  32'h7, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("post6", 3'b001, 1'b1, 32'hD00, 1'b0, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1);
        runStep("post7", 3'b000, 1'b1, 32'hD00, 1'b0, 1'b0, CP0_PEND,  32'h0, 1'b1, 32'h800, 32'h0,   32'h1,   1'b1);
        runStep("post8", 3'b000, 1'b1, 32'hD04, 1'b0, 1'b0, CP0_LEVEL, 32'h0, 1'b0, 32'h0,   32'hD00, 32'h1,   1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
CP0_INTC -- requirements
Module: cp0_intc

Interface
REQ-001 SHALL have parameter N_IRQ, default 3, number of interrupt channels (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 32'h400, vector of the highest-priority channel.
REQ-003 SHALL have parameter VEC_STRIDE, default 32'h200, vector spacing per priority step.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port irq_raw  input  N_IRQ  interrupt lines, synchronous to clk.
REQ-007 SHALL have port pipe_ready  input  1  pipeline is at an interruptible instruction boundary.
REQ-008 SHALL have port pc_next  input  32  return address saved when an interrupt is taken.
REQ-009 SHALL have port eret  input  1  exception-return strobe.
REQ-010 SHALL have ports mtc0_we (input, 1), cp0_addr (input, 5) and mtc0_data (input, 32) forming the CP0 write port.
REQ-011 SHALL have port mfc0_data  output  32  combinational read of register cp0_addr.
REQ-012 SHALL have ports irq_take (output, 1, redirect this cycle) and irq_vector (output, 32, redirect target).
REQ-013 SHALL have ports epc (output, 32, top of EPC stack) and eret_err (output, 1, sticky underflow flag).

Function
REQ-014 SHALL register the previous value of irq_raw; rise = irq_raw & ~prev; pending[i] SHALL set at the clock edge where rise[i]=1.
REQ-015 SHALL let a set from rise win over a W1C clear of the same bit in the same cycle.
REQ-016 SHALL define channel N_IRQ-1 as highest priority; cand = highest i with pending[i] & mask[i].
REQ-017 SHALL drive irq_take = cand valid & ie & (cand+1 > level) & pipe_ready & ~eret, combinationally from registered state.
REQ-018 SHALL drive irq_vector = VEC_BASE + (N_IRQ-1-cand)*VEC_STRIDE (N_IRQ=3: ch2 0x400, ch1 0x600, ch0 0x800); irq_vector SHALL be 0 when irq_take=0.
REQ-019 SHALL, at the edge ending an irq_take cycle: push {pc_next, level} onto the EPC stack (depth N_IRQ), set level=cand+1 and clear pending[cand].
REQ-020 SHALL, on eret with a non-empty stack: pop, restore the saved level and present the new top on epc.
REQ-021 SHALL, on eret with an empty stack: leave all state unchanged and set eret_err (cleared only by reset).
REQ-022 SHALL give eret priority over a take in the same cycle; the take is re-evaluated the next cycle.
REQ-023 SHALL allow nesting only to strictly higher priority, so stack overflow cannot occur; same or lower priority waits for eret.
REQ-024 SHALL decode CP0 addresses: 0x16 ie (bit0, RW); 0x17 mask (N_IRQ bits, RW); 0x0d pending (read, write-1-to-clear); 0x0c level (read-only); 0x0e epc (RW; writes top entry, ignored when stack empty); others read 0, writes ignored.
REQ-025 SHALL have an mtc0 write take effect at the clock edge, so irq_take sees the new value in the following cycle.
REQ-026 SHALL let a same-cycle eret pop take priority over an mtc0 write to 0x0e.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear prev, pending, mask, ie, level, stack pointer and eret_err; irq_take=0, irq_vector=0, epc=0.
REQ-028 SHALL, when reset asserts mid-ISR, discard all nesting state; no eret is needed after release.
REQ-029 SHALL, when irq_raw is already high at reset release, not treat that as an edge (prev reset 0, but pending is masked because mask=0).

Structure
REQ-030 SHALL place CP0 address constants (0x0c, 0x0d, 0x0e, 0x16, 0x17) in the shared cpu package.
REQ-031 SHALL implement the EPC/level stack as the sub-module cp0_epc_stack (push, pop, top, empty, parameter DEPTH).

Verification
REQ-032 SHALL verify single IRQ: ie=1, mask=3'b111, pulse irq_raw[1], pipe_ready=1, pc_next=0x100 -> one-cycle irq_take, irq_vector=0x600, epc=0x100, level=2.
REQ-033 SHALL verify nesting: in ch0 ISR (epc 0x200) raise ch2 with pc_next=0x820 -> take to 0x400; eret -> epc=0x200, level=1; eret -> level=0.
REQ-034 SHALL verify blocking: in ch2 ISR raise ch1 -> no take; after eret -> take to 0x600 the next ready cycle.
REQ-035 SHALL verify gating: mask=3'b000 or ie=0 or pipe_ready=0 with pending ch0 -> irq_take stays 0 and pending reads 3'b001; enabling the gate -> take the following cycle.
REQ-036 SHALL verify the eret/take collision: eret on an empty stack -> eret_err=1, state unchanged; eret and take in the same cycle -> pop only, take next cycle.
REQ-037 SHALL verify reset: drop rst_n during a 2-deep nest -> all outputs 0 immediately; an rst_n pulse cleared asynchronously with no clock.
